// File: rtl/mem_arbiter_if.sv
// Memory arbiter bus: I-cache / D-cache request side, memory port, and read return path.
interface mem_arbiter_if;
  logic        i_req;
  logic [15:0] i_addr;
  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] mem_data;
  logic        mem_data_valid;
  logic        i_gnt;
  logic        d_gnt;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] rdata;
  logic        i_data_valid;
  logic        d_data_valid;
  logic        err;

  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_data, mem_data_valid,
    output i_gnt, d_gnt, mem_en, mem_wr, mem_addr, mem_wdata, rdata,
           i_data_valid, d_data_valid, err
  );

  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_data, mem_data_valid,
    input  i_gnt, d_gnt, mem_en, mem_wr, mem_addr, mem_wdata, rdata,
           i_data_valid, d_data_valid, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-client memory port arbiter (I-cache fill / D-cache access) with a
// fixed-latency read return path. Ownership is held for back-to-back
// accesses; before another client is granted, in-flight reads are drained
// so every return can be routed to the client that issued it.
module mem_arbiter #(
  parameter int MEM_LAT = 4
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {IDLE, I_OWN, D_OWN, DRAIN} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  state_t           state;
  owner_t           owner;
  owner_t           last_owner;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] next_outstanding;
  logic             i_gnt_q;
  logic             d_gnt_q;
  logic             err_q;

  logic             i_acc;
  logic             d_acc;
  logic             rd_issue;
  logic             rd_return;
  logic             spurious;
  logic             mem_en_c;
  logic             mem_wr_c;
  logic [15:0]      mem_addr_c;
  logic [15:0]      mem_wdata_c;

  assign i_acc = i_gnt_q & bus.i_req;
  assign d_acc = d_gnt_q & bus.d_req;

  // Drive the memory port from whichever client holds the grant; an idle port reads as all zeros
  always_comb begin
    mem_en_c    = i_acc | d_acc;
    mem_wr_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    if (i_acc) begin
      mem_addr_c = bus.i_addr;
    end else if (d_acc) begin
      mem_wr_c    = bus.d_wr;
      mem_addr_c  = bus.d_addr;
      mem_wdata_c = bus.d_wdata;
    end
  end

  // A return with nothing outstanding is dropped: it neither decrements nor routes
  assign rd_issue  = mem_en_c & ~mem_wr_c;
  assign rd_return = bus.mem_data_valid & (outstanding != '0);
  assign spurious  = bus.mem_data_valid & (outstanding == '0);

  // Outstanding-read count after this cycle's issue and return
  always_comb begin
    next_outstanding = outstanding;
    if (rd_issue && !rd_return) begin
      next_outstanding = outstanding + CNT_W'(1);
    end else if (!rd_issue && rd_return) begin
      next_outstanding = outstanding - CNT_W'(1);
    end
  end

  // Track in-flight reads and latch the sticky error on an unexpected return
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding <= '0;
      err_q       <= 1'b0;
    end else begin
      outstanding <= next_outstanding;
      if (spurious) begin
        err_q <= 1'b1;
      end
    end
  end

  // Ownership FSM with registered grants; ties go to the client that did not own last
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= OWN_I;
      last_owner <= OWN_I;
      i_gnt_q    <= 1'b0;
      d_gnt_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_req && (!bus.d_req || last_owner == OWN_D)) begin
            state      <= I_OWN;
            owner      <= OWN_I;
            last_owner <= OWN_I;
            i_gnt_q    <= 1'b1;
          end else if (bus.d_req) begin
            state      <= D_OWN;
            owner      <= OWN_D;
            last_owner <= OWN_D;
            d_gnt_q    <= 1'b1;
          end
        end
        I_OWN: begin
          if (!bus.i_req) begin
            i_gnt_q <= 1'b0;
            state   <= (next_outstanding == '0) ? IDLE : DRAIN;
          end
        end
        D_OWN: begin
          if (!bus.d_req) begin
            d_gnt_q <= 1'b0;
            state   <= (next_outstanding == '0) ? IDLE : DRAIN;
          end
        end
        DRAIN: begin
          if (next_outstanding == '0) begin
            state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          i_gnt_q <= 1'b0;
          d_gnt_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.i_gnt        = i_gnt_q;
  assign bus.d_gnt        = d_gnt_q;
  assign bus.mem_en       = mem_en_c;
  assign bus.mem_wr       = mem_wr_c;
  assign bus.mem_addr     = mem_addr_c;
  assign bus.mem_wdata    = mem_wdata_c;
  assign bus.rdata        = bus.mem_data;
  assign bus.i_data_valid = rd_return & (owner == OWN_I);
  assign bus.d_data_valid = rd_return & (owner == OWN_D);
  assign bus.err          = err_q;
endmodule
